// File: rtl/ram_bank_ctrl_if.sv
// ram_bank_ctrl_if
//
// Command/read-back bundle between the switch/command decoder and the RAM
// bank controller.
//
//   master : command source (decoder or testbench)
//   slave  : ram_bank_ctrl
//
// Signals:
//   cmd_valid, cmd_op, cmd_addr, cmd_end, cmd_data, dwell, abort  (master -> slave)
//   cmd_ready, rd_valid, rd_data, rd_addr, busy, done             (slave -> master)
interface ram_bank_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int DWELL_W = 24
);
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [ADDR_W-1:0]  cmd_end;
  logic [DATA_W-1:0]  cmd_data;
  logic [DWELL_W-1:0] dwell;
  logic               abort;

  logic               cmd_ready;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_end, cmd_data, dwell, abort,
    input  cmd_ready, rd_valid, rd_data, rd_addr, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_end, cmd_data, dwell, abort,
    output cmd_ready, rd_valid, rd_data, rd_addr, busy, done
  );
endinterface

// File: rtl/ram_bank_ctrl.sv
// ram_bank_ctrl
//
// Parametrised single-port RAM bank with a command front end. It handles
// registered reads, single writes, a multi-cycle block-fill engine and an
// optional auto-scan mode that steps through an address range for the
// 7-segment display path. The memory array is inferred here and is never
// cleared by reset.
//
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : ram_bank_ctrl_if.slave (command in, read data / status out)
//
// Commands (cmd_op): 00 read, 01 write, 10 fill, 11 scan.
//
// Build option:
//   RAM_SCAN_EN  defined   -> SCAN state, dwell counter and op 11 built in
//                undefined -> op 11 is accepted as a no-op, dwell is unused
module ram_bank_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int DWELL_W = 24
) (
  input  logic            clock,
  input  logic            reset,
  ram_bank_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
`ifdef RAM_SCAN_EN
  localparam logic [1:0] OP_SCAN  = 2'b11;
`endif

`ifdef RAM_SCAN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, SCAN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] fill_data;
`ifdef RAM_SCAN_EN
  logic [ADDR_W-1:0]  start_addr;
  logic [DWELL_W-1:0] dwell_len;
  logic [DWELL_W-1:0] dwell_cnt;
`endif

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_raddr;
  logic              done_set;

  assign accept = bus.cmd_valid && (state == IDLE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort wins over fill completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_FILL: state_nxt = FILL;
`ifdef RAM_SCAN_EN
            OP_SCAN: state_nxt = SCAN;
`endif
            default: state_nxt = IDLE;
          endcase
        end
      end
      FILL: begin
        if (bus.abort || (ptr == end_addr)) begin
          state_nxt = IDLE;
        end
      end
`ifdef RAM_SCAN_EN
      SCAN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode: memory write port, read request, status
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = bus.cmd_addr;
    mem_wdata     = bus.cmd_data;
    rd_en         = 1'b0;
    rd_raddr      = bus.cmd_addr;
    done_set      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept && (bus.cmd_op == OP_WRITE)) begin
          mem_we = 1'b1;
        end
        if (accept && (bus.cmd_op == OP_READ)) begin
          rd_en = 1'b1;
        end
      end
      FILL: begin
        bus.busy = 1'b1;
        // an abort on this edge suppresses the write scheduled for it
        if (!bus.abort) begin
          mem_we    = 1'b1;
          mem_waddr = ptr;
          mem_wdata = fill_data;
          done_set  = (ptr == end_addr);
        end
      end
`ifdef RAM_SCAN_EN
      SCAN: begin
        bus.busy = 1'b1;
        // a new address is read only when its dwell period has run out
        if (!bus.abort && (dwell_cnt == '0)) begin
          rd_en    = 1'b1;
          rd_raddr = ptr;
        end
      end
`endif
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  // Memory array; reset never clears it, but a write on a reset edge is dropped
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read-back register, done pulse, fill/scan pointers and dwell counter
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_addr  <= '0;
      bus.done     <= 1'b0;
      ptr          <= '0;
      end_addr     <= '0;
      fill_data    <= '0;
`ifdef RAM_SCAN_EN
      start_addr   <= '0;
      dwell_len    <= '0;
      dwell_cnt    <= '0;
`endif
    end else begin
      bus.rd_valid <= rd_en;
      bus.done     <= done_set;
      if (rd_en) begin
        bus.rd_data <= mem[rd_raddr];
        bus.rd_addr <= rd_raddr;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            ptr       <= bus.cmd_addr;
            end_addr  <= bus.cmd_end;
            fill_data <= bus.cmd_data;
`ifdef RAM_SCAN_EN
            start_addr <= bus.cmd_addr;
            dwell_len  <= bus.dwell;
            dwell_cnt  <= '0;
`endif
          end
        end
        FILL: begin
          ptr <= ptr + ADDR_W'(1);
        end
`ifdef RAM_SCAN_EN
        SCAN: begin
          if (dwell_cnt == '0) begin
            dwell_cnt <= dwell_len;
            ptr       <= (ptr == end_addr) ? start_addr : ptr + ADDR_W'(1);
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end
`endif
        default: begin
          ptr <= ptr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// tb_ram_bank_ctrl
//
// Directed bench for ram_bank_ctrl with DATA_W=8, ADDR_W=5, DWELL_W=24.
// Inputs change 1 ns after each rising edge; outputs are sampled at the
// same point, so every sample reflects the edge just taken.
module tb_ram_bank_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  ram_bank_ctrl_if #(.DATA_W(8), .ADDR_W(5), .DWELL_W(24)) bus ();

  ram_bank_ctrl #(.DATA_W(8), .ADDR_W(5), .DWELL_W(24)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, land 1 ns after it
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [4:0] a,
                               input logic [4:0] e, input logic [7:0] d,
                               input logic [23:0] dw, input logic ab);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_end   = e;
    bus.cmd_data  = d;
    bus.dwell     = dw;
    bus.abort     = ab;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 8'd0, 24'd0, 1'b0);
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 2'b01, a, 5'd0, d, 24'd0, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [4:0] a, input logic [7:0] expd);
    applyStimulus(1'b1, 2'b00, a, 5'd0, 8'd0, 24'd0, 1'b0);
    checkOutput({tag, "_valid"}, bus.rd_valid, 1);
    checkOutput({tag, "_data"}, bus.rd_data, expd);
    checkOutput({tag, "_addr"}, bus.rd_addr, a);
  endtask

  initial begin
    int busyCycles;
    int n;
    logic doneEarly;
    logic [4:0] sAddr [4];
    logic [7:0] sData [4];
    int sCyc [4];

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idleCycle();
    idleCycle();
    reset = 1'b0;

    // reset state
    checkOutput("rst_ready", bus.cmd_ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_rd_data", bus.rd_data, 0);
    checkOutput("rst_rd_addr", bus.rd_addr, 0);

    // write then read back, single-cycle strobe
    doWrite(5'h03, 8'hA5);
    doRead("rd03", 5'h03, 8'hA5);
    idleCycle();
    checkOutput("rd03_strobe_end", bus.rd_valid, 0);

    // second reset keeps memory, clears read register
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    checkOutput("rst2_rd_data", bus.rd_data, 0);
    checkOutput("rst2_rd_valid", bus.rd_valid, 0);
    doRead("rd03_after_rst", 5'h03, 8'hA5);

    // back-to-back reads
    doWrite(5'h04, 8'h11);
    doRead("b2b_03", 5'h03, 8'hA5);
    doRead("b2b_04", 5'h04, 8'h11);

    // wrapping fill 1E..01 with 3C; 02 must stay untouched
    doWrite(5'h02, 8'h77);
    applyStimulus(1'b1, 2'b10, 5'h1E, 5'h01, 8'h3C, 24'd0, 1'b0);
    checkOutput("fill_ready_low", bus.cmd_ready, 0);
    busyCycles = 0;
    doneEarly  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      busyCycles++;
      if (bus.done) doneEarly = 1'b1;
      idleCycle();
    end
    checkOutput("fill_busy_cycles", busyCycles, 4);
    checkOutput("fill_done_early", doneEarly, 0);
    checkOutput("fill_done", bus.done, 1);
    checkOutput("fill_ready_back", bus.cmd_ready, 1);
    idleCycle();
    checkOutput("fill_done_pulse_end", bus.done, 0);
    doRead("fill_1E", 5'h1E, 8'h3C);
    doRead("fill_1F", 5'h1F, 8'h3C);
    doRead("fill_00", 5'h00, 8'h3C);
    doRead("fill_01", 5'h01, 8'h3C);
    doRead("fill_02", 5'h02, 8'h77);

    // fill 00..07 with 55, abort on the 3rd FILL cycle
    doWrite(5'h02, 8'hEE);
    applyStimulus(1'b1, 2'b10, 5'h00, 5'h07, 8'h55, 24'd0, 1'b0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 8'd0, 24'd0, 1'b1);
    checkOutput("abort_ready", bus.cmd_ready, 1);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    idleCycle();
    checkOutput("abort_done_later", bus.done, 0);
    doRead("abort_00", 5'h00, 8'h55);
    doRead("abort_01", 5'h01, 8'h55);
    doRead("abort_02", 5'h02, 8'hEE);
    doRead("abort_03", 5'h03, 8'hA5);

    // preload for scan / no-op checks
    doWrite(5'h00, 8'h10);
    doWrite(5'h01, 8'h11);
    doWrite(5'h02, 8'h12);

`ifdef RAM_SCAN_EN
    applyStimulus(1'b1, 2'b11, 5'h00, 5'h02, 8'h00, 24'd1, 1'b0);
    checkOutput("scan_ready_low", bus.cmd_ready, 0);
    checkOutput("scan_busy", bus.busy, 1);
    n = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      idleCycle();
      if (bus.rd_valid) begin
        sAddr[n] = bus.rd_addr;
        sData[n] = bus.rd_data;
        sCyc[n]  = cyc;
        n++;
        if (n == 4) break;
      end
    end
    checkOutput("scan_strobe_count", n, 4);
    if (n == 4) begin
      checkOutput("scan_addr0", sAddr[0], 5'h00);
      checkOutput("scan_addr1", sAddr[1], 5'h01);
      checkOutput("scan_addr2", sAddr[2], 5'h02);
      checkOutput("scan_addr3", sAddr[3], 5'h00);
      checkOutput("scan_data0", sData[0], 8'h10);
      checkOutput("scan_data1", sData[1], 8'h11);
      checkOutput("scan_data2", sData[2], 8'h12);
      checkOutput("scan_data3", sData[3], 8'h10);
      checkOutput("scan_first_cycle", sCyc[0], 1);
      checkOutput("scan_gap1", sCyc[1] - sCyc[0], 2);
      checkOutput("scan_gap2", sCyc[2] - sCyc[1], 2);
      checkOutput("scan_gap3", sCyc[3] - sCyc[2], 2);
    end
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 8'd0, 24'd0, 1'b1);
    checkOutput("scan_abort_busy", bus.busy, 0);
    checkOutput("scan_abort_ready", bus.cmd_ready, 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rd_valid) n++;
      idleCycle();
    end
    checkOutput("scan_no_strobe_after_abort", n, 0);
`else
    applyStimulus(1'b1, 2'b11, 5'h00, 5'h02, 8'h00, 24'd1, 1'b0);
    checkOutput("noop_busy", bus.busy, 0);
    checkOutput("noop_rd_valid", bus.rd_valid, 0);
    checkOutput("noop_ready", bus.cmd_ready, 1);
    idleCycle();
    checkOutput("noop_busy_later", bus.busy, 0);
    checkOutput("noop_rd_valid_later", bus.rd_valid, 0);
    doRead("noop_then_read", 5'h01, 8'h11);
`endif

    // reset in the middle of a fill 08..0F with 99
    doWrite(5'h0A, 8'h42);
    doRead("pre_rst_fill", 5'h03, 8'hA5);
    applyStimulus(1'b1, 2'b10, 5'h08, 5'h0F, 8'h99, 24'd0, 1'b0);
    idleCycle();
    idleCycle();
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    checkOutput("rstfill_busy", bus.busy, 0);
    checkOutput("rstfill_done", bus.done, 0);
    checkOutput("rstfill_rd_valid", bus.rd_valid, 0);
    checkOutput("rstfill_rd_data", bus.rd_data, 0);
    checkOutput("rstfill_rd_addr", bus.rd_addr, 0);
    checkOutput("rstfill_ready", bus.cmd_ready, 1);
    idleCycle();
    checkOutput("rstfill_no_done", bus.done, 0);
    doRead("rstfill_08", 5'h08, 8'h99);
    doRead("rstfill_09", 5'h09, 8'h99);
    doRead("rstfill_0A", 5'h0A, 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bank_ctrl.md
# ram_bank_ctrl

Parametrised single-port RAM bank with a command front end, the next generation of the board-level RAM exercise. It adds configurable width and depth, registered reads with a valid strobe, a multi-cycle block-fill engine, and an optional auto-scan mode that steps through an address range for the 7-segment display path. It sits between the switch/command decoder and the `display` instances; the memory array is inferred inside the block.

## Interface

Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 5: address width; depth is 2^ADDR_W.
- `DWELL_W`, 24: width of the scan dwell counter.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  00 read, 01 write, 10 fill, 11 scan.
- `cmd_addr`  in  ADDR_W  read/write address, or fill/scan start address.
- `cmd_end`  in  ADDR_W  fill/scan end address, inclusive.
- `cmd_data`  in  DATA_W  write/fill data.
- `dwell`  in  DWELL_W  scan hold, in cycles minus one; sampled at scan accept.
- `abort`  in  1  terminates a fill or scan.
- `cmd_ready`  out  1  high iff state is IDLE; combinational.
- `rd_valid`  out  1  one-cycle strobe; `rd_data`/`rd_addr` are new.
- `rd_data`  out  DATA_W  registered read data.
- `rd_addr`  out  ADDR_W  address of `rd_data`.
- `busy`  out  1  high in FILL or SCAN.
- `done`  out  1  one-cycle pulse on normal fill completion.

## Operation

- A command is accepted on an edge where `cmd_valid && cmd_ready`.
- States: IDLE, FILL, SCAN. Reset forces IDLE and clears `rd_valid`, `rd_data`, `rd_addr`, `done`, the internal pointers and the counters to 0. Memory contents are never cleared by reset.
- Read: handled in IDLE. `rd_data = mem[cmd_addr]` and `rd_addr = cmd_addr` are registered, with `rd_valid` high for the following cycle. Back-to-back reads run at one per cycle.
- Write: handled in IDLE. `mem[cmd_addr] <= cmd_data` at the accept edge. A read of the same address in the next cycle returns the new value.
- Fill: latch the start, end and data, then go to FILL.
  - One word is written per cycle, starting at the start address and incrementing modulo 2^ADDR_W.
  - The engine wraps past 2^ADDR_W-1 to 0 when end < start.
  - Word count = ((end − start) mod 2^ADDR_W) + 1. start == end writes one word.
- Scan: latch the start, end and dwell, then go to SCAN.
  - Reads the current address and emits a `rd_valid` strobe.
  - Holds that address for dwell+1 cycles, then advances modulo 2^ADDR_W.
  - After the end address it returns to the start address and loops forever.
  - Never writes memory.
- Abort:
  - In FILL or SCAN, `abort` sampled high returns the block to IDLE at that edge. A write scheduled on that edge is suppressed, and `done` is not pulsed.
  - In IDLE, `abort` is ignored; a simultaneous command is accepted.
- Reset mid-fill: the block goes to IDLE. Words already written keep their values, and `done` is not pulsed.
- A `cmd_valid` that arrives while busy is not accepted. The command source holds it until `cmd_ready`.

## Timing

- Read latency: accept at edge E0, data valid in the cycle after E0 (`rd_valid` 1 cycle).
- Fill: accept at E0, writes at edges E1..Ek (k = word count). The state returns to IDLE at Ek, `busy` is high for exactly k cycles, `done` is high for the cycle after Ek, and `cmd_ready` is high from Ek.
- Scan: accept at E0, and the first `rd_valid` is the cycle after E1. Subsequent strobes come every dwell+1 cycles. dwell = 0 gives one new address per cycle.
- Abort/reset take effect at the sampling edge, so `cmd_ready` is high in the next cycle.

## Configuration

- `RAM_SCAN_EN` defined: SCAN state, dwell counter and op 11 are compiled in as described.
- `RAM_SCAN_EN` undefined:
  - No SCAN state or dwell counter is built.
  - op 11 is accepted in IDLE as a no-op: no `rd_valid`, `busy` stays low.
  - The `dwell` port remains present and unused.

## Test plan

All scenarios use DATA_W=8 and ADDR_W=5.

- Reset, then write 0xA5 @0x03, then read 0x03 → `rd_valid` one cycle after the read accept, `rd_data`=0xA5, `rd_addr`=0x03. Reads of untouched addresses are unaffected by a second reset.
- Fill start 0x1E, end 0x01, data 0x3C → `busy` 4 cycles, `done` 1 cycle. Reads of 0x1E, 0x1F, 0x00, 0x01 return 0x3C; 0x02 is unchanged.
- Fill 0x00..0x07 with 0x55, `abort` at the 3rd FILL cycle → only 0x00, 0x01 hold 0x55, `done` stays 0, `cmd_ready` is 1 the next cycle.
- Scan 0x00..0x02, dwell 1, preloaded 0x10/0x11/0x12 → `rd_valid` every 2 cycles with `rd_addr` sequence 00, 01, 02, 00 and matching data. `abort` → IDLE, no further strobes.
- `reset` asserted mid-fill → all outputs 0 next cycle, state IDLE, already-written words retained.
- Without `RAM_SCAN_EN`: op 11 accepted → `busy`=0, no `rd_valid`. A following read works at normal latency.
